// File: rtl/osd_host_link_pkg.sv
// Shared types and widths for the host-side GLIP/DII bridge.
// State encodings for both FSMs and the length-word width used by the RX counter.
package osd_host_link_pkg;

  localparam int MAX_PKT_LEN_DEF = 12;
  // GLIP length words are a full 16-bit word, so the RX remaining count is too.
  localparam int LEN_W = 16;

  typedef enum logic [1:0] {FILL, HDR, SEND, DROP} tx_state_t;
  typedef enum logic {LEN, DATA} rx_state_t;

endpackage

// File: rtl/osd_host_link_txbuf.sv
// Single-packet register-file buffer for the TX path with write/read counters.
// Write at wcnt, combinational read at rcnt; no flow control of its own.
module osd_host_link_txbuf #(
  parameter int DEPTH = 12,
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wcnt_clr,
  input  logic             rcnt_clr,
  input  logic             rcnt_inc,
  output logic [CW-1:0]    wcnt,
  output logic [CW-1:0]    rcnt,
  output logic [WIDTH-1:0] rd_data
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && (wcnt < DEPTH_C)) mem[wcnt] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
      rcnt <= '0;
    end else begin
      if (wcnt_clr)   wcnt <= '0;
      else if (wr_en) wcnt <= wcnt + CW'(1);
      if (rcnt_clr)      rcnt <= '0;
      else if (rcnt_inc) rcnt <= rcnt + CW'(1);
    end
  end

  assign rd_data = (rcnt < DEPTH_C) ? mem[rcnt] : '0;

endmodule

// File: rtl/osd_host_link.sv
// Host-side DII<->GLIP bridge: TX buffers a whole packet then emits length+flits,
// RX strips the length word and passes flits through with zero latency.
module osd_host_link
  import osd_host_link_pkg::*;
#(
  parameter int MAX_PKT_LEN = MAX_PKT_LEN_DEF,
  parameter int WIDTH       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] dii_in_data,
  input  logic             dii_in_last,
  input  logic             dii_in_valid,
  output logic             dii_in_ready,
  output logic [WIDTH-1:0] glip_out_data,
  output logic             glip_out_valid,
  input  logic             glip_out_ready,
  input  logic [WIDTH-1:0] glip_in_data,
  input  logic             glip_in_valid,
  output logic             glip_in_ready,
  output logic [WIDTH-1:0] dii_out_data,
  output logic             dii_out_last,
  output logic             dii_out_valid,
  input  logic             dii_out_ready,
  output logic             err_oversize,
  output logic             err_rx_len
);

  localparam int CW = $clog2(MAX_PKT_LEN + 1);
  localparam logic [CW-1:0]    MAXC     = CW'(MAX_PKT_LEN);
  localparam logic [LEN_W-1:0] MAX_WORD = LEN_W'(MAX_PKT_LEN);

  tx_state_t        tx_state;
  logic             tx_live;
  logic [CW-1:0]    tx_len;
  logic [CW-1:0]    wcnt;
  logic [CW-1:0]    rcnt;
  logic [WIDTH-1:0] rd_data;
  logic             in_acc;
  logic             out_acc;
  logic             send_done;
  logic             buf_wr;
  logic             buf_wclr;

  // tx_live keeps ready low while reset is held, even though the state is FILL.
  assign dii_in_ready   = tx_live && ((tx_state == FILL) || (tx_state == DROP));
  assign glip_out_valid = (tx_state == HDR) || (tx_state == SEND);
  assign in_acc    = dii_in_valid && dii_in_ready;
  assign out_acc   = glip_out_valid && glip_out_ready;
  assign send_done = (tx_state == SEND) && out_acc && (rcnt == tx_len - CW'(1));
  assign buf_wr    = (tx_state == FILL) && in_acc && (wcnt != MAXC);
  assign buf_wclr  = ((tx_state == FILL) && in_acc && (wcnt == MAXC) && dii_in_last) ||
                     ((tx_state == DROP) && in_acc && dii_in_last) ||
                     send_done;

  always_comb begin
    glip_out_data = '0;
    case (tx_state)
      HDR:     glip_out_data = WIDTH'(tx_len);
      SEND:    glip_out_data = rd_data;
      default: ;
    endcase
  end

  osd_host_link_txbuf #(
    .DEPTH (MAX_PKT_LEN),
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_txbuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (buf_wr),
    .wr_data  (dii_in_data),
    .wcnt_clr (buf_wclr),
    .rcnt_clr ((tx_state == HDR) && out_acc),
    .rcnt_inc ((tx_state == SEND) && out_acc),
    .wcnt     (wcnt),
    .rcnt     (rcnt),
    .rd_data  (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state     <= FILL;
      tx_len       <= '0;
      tx_live      <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      tx_live      <= 1'b1;
      err_oversize <= 1'b0;
      case (tx_state)
        FILL: if (in_acc) begin
          // A flit arriving with the buffer already full overflows the packet.
          if (wcnt == MAXC) begin
            if (dii_in_last) err_oversize <= 1'b1;
            else             tx_state     <= DROP;
          end else if (dii_in_last) begin
            tx_len   <= wcnt + CW'(1);
            tx_state <= HDR;
          end
        end
        DROP: if (in_acc && dii_in_last) begin
          err_oversize <= 1'b1;
          tx_state     <= FILL;
        end
        HDR:  if (out_acc)   tx_state <= SEND;
        SEND: if (send_done) tx_state <= FILL;
        default: tx_state <= FILL;
      endcase
    end
  end

  rx_state_t        rx_state;
  logic             rx_live;
  logic [LEN_W-1:0] rem;
  logic             rx_acc;

  assign glip_in_ready = (rx_state == DATA) ? dii_out_ready : rx_live;
  assign dii_out_valid = (rx_state == DATA) && glip_in_valid;
  assign dii_out_data  = (rx_state == DATA) ? glip_in_data : '0;
  assign dii_out_last  = (rx_state == DATA) && (rem == LEN_W'(1));
  assign rx_acc        = glip_in_valid && glip_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= LEN;
      rem        <= '0;
      rx_live    <= 1'b0;
      err_rx_len <= 1'b0;
    end else begin
      rx_live    <= 1'b1;
      err_rx_len <= 1'b0;
      case (rx_state)
        LEN: if (rx_acc) begin
          if (glip_in_data == '0) begin
            err_rx_len <= 1'b1;
          end else begin
            // Oversized lengths are flagged but still forwarded to keep framing.
            rem      <= glip_in_data;
            rx_state <= DATA;
            if (glip_in_data > MAX_WORD) err_rx_len <= 1'b1;
          end
        end
        DATA: if (rx_acc) begin
          rem <= rem - LEN_W'(1);
          if (rem == LEN_W'(1)) rx_state <= LEN;
        end
        default: rx_state <= LEN;
      endcase
    end
  end

endmodule

// File: tb/tb_osd_host_link.sv
// Bench for osd_host_link: vector tables, reset-in-flight sequence and random traffic
// checked against a packet-level model of both paths.
module tb_osd_host_link;

  localparam int MAX = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] dii_in_data = '0;
  logic        dii_in_last = 1'b0;
  logic        dii_in_valid = 1'b0;
  logic        dii_in_ready;
  logic [15:0] glip_out_data;
  logic        glip_out_valid;
  logic        glip_out_ready = 1'b0;
  logic [15:0] glip_in_data = '0;
  logic        glip_in_valid = 1'b0;
  logic        glip_in_ready;
  logic [15:0] dii_out_data;
  logic        dii_out_last;
  logic        dii_out_valid;
  logic        dii_out_ready = 1'b0;
  logic        err_oversize;
  logic        err_rx_len;

  always #5 clk = ~clk;

  osd_host_link #(.MAX_PKT_LEN(MAX), .WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .dii_in_data(dii_in_data), .dii_in_last(dii_in_last),
    .dii_in_valid(dii_in_valid), .dii_in_ready(dii_in_ready),
    .glip_out_data(glip_out_data), .glip_out_valid(glip_out_valid),
    .glip_out_ready(glip_out_ready),
    .glip_in_data(glip_in_data), .glip_in_valid(glip_in_valid),
    .glip_in_ready(glip_in_ready),
    .dii_out_data(dii_out_data), .dii_out_last(dii_out_last),
    .dii_out_valid(dii_out_valid), .dii_out_ready(dii_out_ready),
    .err_oversize(err_oversize), .err_rx_len(err_rx_len)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] tx_exp[$];
  logic [15:0] tx_obs[$];
  int          tx_stamp[$];
  logic [16:0] rx_exp[$];
  logic [16:0] rx_obs[$];
  int tx_ob = 0, rx_ob = 0;
  int ov_cnt = 0, ov_base = 0, ov_exp = 0;
  int rxe_cnt = 0, rxe_base = 0, rxe_exp = 0;
  int last_acc = 0;
  int tx_bp = 0, rx_bp = 0, rx_bp_start = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Backpressure generators for both sink sides.
  always @(posedge clk) begin
    #1;
    case (tx_bp)
      0:       glip_out_ready = 1'b1;
      1:       glip_out_ready = ~glip_out_ready;
      default: glip_out_ready = 1'($urandom_range(0, 1));
    endcase
    case (rx_bp)
      0:       dii_out_ready = 1'b1;
      1:       dii_out_ready = ~dii_out_ready;
      2:       dii_out_ready = 1'($urandom_range(0, 1));
      default: dii_out_ready = (cyc - rx_bp_start) >= 3;
    endcase
  end

  // Monitor: handshakes, error pulses, TX hold-under-backpressure and busy rules.
  logic        pv = 1'b0, prdy = 1'b0;
  logic [15:0] pd = '0;
  always @(negedge clk) begin
    if (glip_out_valid && glip_out_ready) begin
      tx_obs.push_back(glip_out_data);
      tx_stamp.push_back(cyc);
    end
    if (dii_out_valid && dii_out_ready) rx_obs.push_back({dii_out_last, dii_out_data});
    if (err_oversize) ov_cnt++;
    if (err_rx_len)   rxe_cnt++;
    if (pv && !prdy && rst_n) begin
      chk("tx_hold_valid", 32'(glip_out_valid), 32'd1);
      chk("tx_hold_data", 32'(glip_out_data), 32'(pd));
    end
    if (glip_out_valid) chk("tx_busy_in_ready", 32'(dii_in_ready), 32'd0);
    pv   = glip_out_valid;
    prdy = glip_out_ready;
    pd   = glip_out_data;
  end

  task automatic tx_flit(input logic [15:0] d, input logic l);
    logic r;
    bit ok = 0;
    dii_in_data = d; dii_in_last = l; dii_in_valid = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      r = dii_in_ready;
      if (r) last_acc = cyc;
      @(posedge clk); #1;
      if (r) begin ok = 1; break; end
    end
    if (!ok) chk("tx_accept_timeout", 32'd0, 32'd1);
    dii_in_valid = 1'b0; dii_in_last = 1'b0;
  endtask

  task automatic rx_word(input logic [15:0] d);
    logic r;
    bit ok = 0;
    glip_in_data = d; glip_in_valid = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      r = glip_in_ready;
      @(posedge clk); #1;
      if (r) begin ok = 1; break; end
    end
    if (!ok) chk("rx_accept_timeout", 32'd0, 32'd1);
    glip_in_valid = 1'b0;
  endtask

  // Model: a legal packet becomes {length, flits}; an oversized one vanishes with one error.
  task automatic send_tx(input int n, input logic [15:0] base, input logic [15:0] step);
    logic [15:0] d;
    if (n <= MAX) tx_exp.push_back(16'(n)); else ov_exp++;
    for (int i = 0; i < n; i++) begin
      d = base + step * 16'(i);
      if (n <= MAX) tx_exp.push_back(d);
      tx_flit(d, i == n - 1);
    end
  endtask

  // Model: length word n yields n flits, last on the final one; 0 or >MAX flags an error.
  task automatic send_rx(input int n, input logic [15:0] base, input logic [15:0] step);
    logic [15:0] d;
    if (n == 0 || n > MAX) rxe_exp++;
    rx_word(16'(n));
    for (int i = 0; i < n; i++) begin
      d = base + step * 16'(i);
      rx_exp.push_back({i == n - 1, d});
      rx_word(d);
    end
  endtask

  task automatic drain();
    bit done = 0;
    for (int k = 0; k < 2000; k++) begin
      if (tx_obs.size() - tx_ob >= tx_exp.size() && rx_obs.size() - rx_ob >= rx_exp.size()) begin
        done = 1; break;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic compare_all();
    chk("tx_word_count", 32'(tx_obs.size() - tx_ob), 32'(tx_exp.size()));
    for (int i = 0; i < tx_exp.size(); i++)
      if (tx_ob + i < tx_obs.size()) chk("tx_word", 32'(tx_obs[tx_ob + i]), 32'(tx_exp[i]));
    chk("rx_flit_count", 32'(rx_obs.size() - rx_ob), 32'(rx_exp.size()));
    for (int i = 0; i < rx_exp.size(); i++)
      if (rx_ob + i < rx_obs.size()) chk("rx_flit", 32'(rx_obs[rx_ob + i]), 32'(rx_exp[i]));
    chk("oversize_pulses", 32'(ov_cnt - ov_base), 32'(ov_exp));
    chk("rx_len_err_pulses", 32'(rxe_cnt - rxe_base), 32'(rxe_exp));
    tx_ob = tx_obs.size(); rx_ob = rx_obs.size();
    ov_base = ov_cnt; rxe_base = rxe_cnt;
    ov_exp = 0; rxe_exp = 0;
    tx_exp.delete(); rx_exp.delete();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_glip_out_valid"}, 32'(glip_out_valid), 32'd0);
    chk({tag, "_glip_out_data"},  32'(glip_out_data),  32'd0);
    chk({tag, "_dii_in_ready"},   32'(dii_in_ready),   32'd0);
    chk({tag, "_glip_in_ready"},  32'(glip_in_ready),  32'd0);
    chk({tag, "_dii_out_valid"},  32'(dii_out_valid),  32'd0);
    chk({tag, "_dii_out_data"},   32'(dii_out_data),   32'd0);
    chk({tag, "_dii_out_last"},   32'(dii_out_last),   32'd0);
    chk({tag, "_err_oversize"},   32'(err_oversize),   32'd0);
    chk({tag, "_err_rx_len"},     32'(err_rx_len),     32'd0);
  endtask

  typedef struct {
    int          n;
    logic [15:0] base;
    logic [15:0] step;
    int          bp;
    int          exp_items;
    int          exp_err;
  } vec_t;

  vec_t txv[6];
  vec_t rxv[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    txv[0] = '{3,  16'h1111, 16'h1111, 0, 4,  0};
    txv[1] = '{12, 16'h0100, 16'h0001, 1, 13, 0};
    txv[2] = '{13, 16'h0200, 16'h0001, 0, 0,  1};
    txv[3] = '{1,  16'hABCD, 16'h0000, 0, 2,  0};
    txv[4] = '{14, 16'h0300, 16'h0001, 2, 0,  1};
    txv[5] = '{5,  16'h0400, 16'h0101, 2, 6,  0};
    rxv[0] = '{2,  16'hBEEF, 16'h0C0F, 3, 2,  0};
    rxv[1] = '{0,  16'h0000, 16'h0000, 0, 0,  1};
    rxv[2] = '{1,  16'h5555, 16'h0000, 0, 1,  0};
    rxv[3] = '{13, 16'h0600, 16'h0001, 1, 13, 1};
    rxv[4] = '{12, 16'h0700, 16'h0003, 2, 12, 0};

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_dii_in_ready", 32'(dii_in_ready), 32'd1);
    chk("post_reset_glip_in_ready", 32'(glip_in_ready), 32'd1);

    for (int vi = 0; vi < 6; vi++) begin
      tx_bp = txv[vi].bp;
      send_tx(txv[vi].n, txv[vi].base, txv[vi].step);
      drain();
      chk("tx_vec_words", 32'(tx_obs.size() - tx_ob), 32'(txv[vi].exp_items));
      chk("tx_vec_err", 32'(ov_cnt - ov_base), 32'(txv[vi].exp_err));
      if (vi == 0)
        for (int k = 0; k < 4; k++)
          if (tx_ob + k < tx_stamp.size())
            chk("tx3_cycle", 32'(tx_stamp[tx_ob + k]), 32'(last_acc + 1 + k));
      compare_all();
    end
    tx_bp = 0;

    for (int vi = 0; vi < 5; vi++) begin
      rx_bp = rxv[vi].bp;
      rx_bp_start = cyc;
      send_rx(rxv[vi].n, rxv[vi].base, rxv[vi].step);
      drain();
      chk("rx_vec_flits", 32'(rx_obs.size() - rx_ob), 32'(rxv[vi].exp_items));
      chk("rx_vec_err", 32'(rxe_cnt - rxe_base), 32'(rxv[vi].exp_err));
      compare_all();
    end
    rx_bp = 0;

    // Reset while TX is mid-SEND (2 of 5 flits out) and RX is mid-DATA.
    rx_word(16'd4);
    rx_word(16'h7777);
    for (int i = 0; i < 5; i++) tx_flit(16'h9000 + 16'(i), i == 4);
    for (int k = 0; k < 100; k++) begin
      if (tx_obs.size() - tx_ob >= 3) break;
      @(posedge clk);
    end
    #1;
    chk("pre_reset_tx_busy", 32'(glip_out_valid), 32'd1);
    rst_n = 1'b0;
    glip_in_valid = 1'b1;
    glip_in_data  = 16'h8888;
    #1;
    check_idle("reset_mid");
    glip_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tx_ob = tx_obs.size(); rx_ob = rx_obs.size();
    ov_base = ov_cnt; rxe_base = rxe_cnt;
    rst_n = 1'b1;
    fork
      send_tx(1, 16'h4242, 16'h0000);
      send_rx(1, 16'h2424, 16'h0000);
    join
    drain();
    compare_all();

    // Random concurrent traffic on both paths.
    for (int it = 0; it < 15; it++) begin
      tx_bp = $urandom_range(0, 2);
      rx_bp = $urandom_range(0, 2);
      fork
        begin
          for (int p = 0; p < 3; p++)
            send_tx($urandom_range(1, 14), 16'($urandom), 16'($urandom));
        end
        begin
          for (int q = 0; q < 3; q++)
            send_rx($urandom_range(0, 14), 16'($urandom), 16'($urandom));
        end
      join
      drain();
      compare_all();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/osd_host_link.md
Name: osd_host_link

Overview:
- Host-side counterpart of the system's debug host interface. Sits on the GLIP channel pair in place of, or beside, the TCP GLIP toplevel.
- TX path: accepts complete DII packets from a host-side driver, buffers each one, and emits it on GLIP as a length word followed by the flits.
- RX path: takes the length-prefixed GLIP word stream coming out of the system and turns it back into DII flits with `last` marked.
- Used by simulation benches and FPGA host bridges to talk to the debug NoC without the TCP stack.

Parameters:
- MAX_PKT_LEN, 12, maximum flits per DII packet (equals DEBUG_MAX_PKT_LEN).
- WIDTH, 16, GLIP word width and DII flit data width; must be 16.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assertion, active-low.
- dii_in_data  in  16  host→system flit.
- dii_in_last  in  1  final flit of the packet.
- dii_in_valid  in  1  flit valid.
- dii_in_ready  out  1  flit accepted when valid&ready.
- glip_out_data  out  16  word to the system's GLIP input FIFO.
- glip_out_valid  out  1  word valid.
- glip_out_ready  in  1  system accepts the word.
- glip_in_data  in  16  word from the system's GLIP output FIFO.
- glip_in_valid  in  1  word valid.
- glip_in_ready  out  1  this block accepts the word.
- dii_out_data  out  16  system→host flit.
- dii_out_last  out  1  final flit of the packet.
- dii_out_valid  out  1  flit valid.
- dii_out_ready  in  1  host accepts the flit.
- err_oversize  out  1  one-cycle pulse: TX packet dropped because it was too long.
- err_rx_len  out  1  one-cycle pulse: RX length word was 0 or greater than MAX_PKT_LEN.

Behaviour:
- Reset values: all valid/ready outputs 0, data outputs 0, error pulses 0. Both FSMs enter their idle/header state.
- Reset mid-packet aborts the packet and clears all counters. No partial packet is emitted after reset.

TX FSM, states FILL, HDR, SEND, DROP:
- FILL:
  - dii_in_ready=1.
  - Each accepted flit is written to buf[wcnt], then wcnt++.
  - If the accepted flit has last=1 and wcnt+1 ≤ MAX_PKT_LEN, the length latches as wcnt+1 and the FSM goes to HDR.
  - If a flit is accepted while wcnt==MAX_PKT_LEN and last=0, the FSM goes to DROP.
- DROP:
  - dii_in_ready=1; flits are discarded.
  - On the accepted last flit: err_oversize pulses in the following cycle, wcnt clears, and the FSM returns to FILL.
- HDR:
  - glip_out_data=length, glip_out_valid=1.
  - On handshake, rcnt=0 and the FSM goes to SEND.
- SEND:
  - glip_out_data=buf[rcnt], glip_out_valid=1.
  - On handshake rcnt++. When the handshake occurs with rcnt==length-1, wcnt clears and the FSM goes to FILL.
- dii_in_ready=0 in HDR and SEND; the block holds one packet at a time.
- glip_out_valid stays asserted and glip_out_data stays stable until ready. This holds across any number of backpressure cycles.
- Minimum latency: last flit accepted in cycle N → header valid in cycle N+1 → first flit in N+2, given ready=1 throughout.
- Counters are $clog2(MAX_PKT_LEN+1) bits wide. A packet of exactly MAX_PKT_LEN flits is legal.

RX FSM, states LEN, DATA:
- LEN:
  - glip_in_ready=1 and dii_out_valid=0.
  - The accepted word is the remaining count.
  - Word in 1..MAX_PKT_LEN: load rem=word and go to DATA.
  - Word 0: err_rx_len pulses and the FSM stays in LEN.
  - Word > MAX_PKT_LEN: err_rx_len pulses, but the packet is still forwarded with rem=word. Words are 16 bits, so the counter is 16 bits.
- DATA is a combinational pass-through:
  - dii_out_data=glip_in_data, dii_out_valid=glip_in_valid, glip_in_ready=dii_out_ready.
  - dii_out_last=(rem==1).
  - On handshake rem--. At rem==1 the FSM goes to LEN.
  - Zero added latency; no buffering.
- The TX and RX paths are fully independent. Simultaneous activity on both is legal.

Decomposition:
- Package osd_host_link_pkg holds:
  - tx_state_t {FILL,HDR,SEND,DROP} and rx_state_t {LEN,DATA};
  - the constant LEN_W.
- One sub-module, osd_host_link_txbuf: the MAX_PKT_LEN×16 register-file packet buffer with wcnt/rcnt. The RX path stays inline.

Test Plan:
- TX 3-flit packet 0x1111, 0x2222, 0x3333(last), glip_out_ready=1 → GLIP words 0x0003, 0x1111, 0x2222, 0x3333 in consecutive cycles. dii_in_ready is 0 from the header cycle until the last word is sent.
- TX 12-flit packet with glip_out_ready toggling 1/0 → length word 0x000C, then 12 flits in order, each held stable while ready=0, no error.
- TX 13-flit packet, then a 1-flit packet 0xABCD → err_oversize pulses once and nothing is emitted for the first packet; then 0x0001, 0xABCD.
- RX words 0x0002, 0xBEEF, 0xCAFE with dii_out_ready=0 for 3 cycles → no loss. 0xCAFE arrives with last=1 and 0xBEEF with last=0.
- RX word 0x0000, then 0x0001, 0x5555 → err_rx_len pulses once; a single flit 0x5555 is delivered with last=1.
- Deassert rst_n during TX SEND after 2 of 5 flits and during RX DATA → all outputs return to reset values immediately. A subsequent 1-flit packet works correctly on both paths.
